if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the synchronous instruction ROM.
- Generates the fetch PC and drives the ROM word address. Absorbs the ROM's 1-cycle read latency and presents {pc, instruction, valid} to decode.
- Supports downstream stall and a taken-branch/jump redirect.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch_if.sv | 28 ++
 rtl/if_fetch.sv | 76 +++++++
 tb/tb_if_fetch.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
// Imported by the fetch interface, the stage and its bench.
package if_fetch_pkg;

  localparam int          DEF_ROM_ADDR_W = 11;
  localparam int          ROM_DEPTH      = 1 << DEF_ROM_ADDR_W;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] ISA_NOP        = 32'h0000_0013;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t insn;
    logic  valid;
    logic  mis;
  } if_id_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: redirect/stall control, ROM port and decode output.
// master = fetch stage, slave = environment (decode, branch unit, ROM).
interface if_fetch_if #(
  parameter int AW = 11
);
  import if_fetch_pkg::*;

  logic        stall;
  logic        br_taken;
  word_t       br_addr;
  logic [AW-1:0] rom_addr;
  word_t       rom_data;
  word_t       if_pc;
  word_t       if_insn;
  logic        if_valid;
  logic        if_misalign;

  modport master (
    input  stall, br_taken, br_addr, rom_data,
    output rom_addr, if_pc, if_insn, if_valid, if_misalign
  );

  modport slave (
    output stall, br_taken, br_addr, rom_data,
    input  rom_addr, if_pc, if_insn, if_valid, if_misalign
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage in front of a 1-cycle synchronous ROM.
// Presents {pc, insn, valid, misalign} to decode; supports stall/redirect.
import if_fetch_pkg::*;

module if_fetch #(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          ROM_ADDR_W = DEF_ROM_ADDR_W,
  parameter logic [31:0] NOP_INSN   = ISA_NOP
) (
  input  logic clk,
  input  logic reset,
  if_fetch_if.master bus
);

  word_t r_fpc;
  word_t r_req_pc;
  logic  r_req_valid;
  logic  r_req_mis;

  word_t w_br_word;
  word_t w_fpc_nx;
  word_t w_req_pc_nx;
  logic  w_req_valid_nx;
  logic  w_req_mis_nx;
  logic [ROM_ADDR_W-1:0] w_rom_addr;

  assign w_br_word = {bus.br_addr[31:2], 2'b00};

  // Stall re-reads the presented word so rom_data stays put.
  always_comb begin
    w_rom_addr = r_fpc[ROM_ADDR_W+1:2];
    if (bus.br_taken)
      w_rom_addr = bus.br_addr[ROM_ADDR_W+1:2];
    else if (bus.stall)
      w_rom_addr = r_req_pc[ROM_ADDR_W+1:2];
  end

  always_comb begin
    w_fpc_nx       = r_fpc;
    w_req_pc_nx    = r_req_pc;
    w_req_valid_nx = r_req_valid;
    w_req_mis_nx   = r_req_mis;
    if (bus.br_taken) begin
      w_req_pc_nx    = w_br_word;
      w_req_valid_nx = 1'b1;
      w_req_mis_nx   = |bus.br_addr[1:0];
      w_fpc_nx       = w_br_word + 32'd4;
    end else if (!bus.stall) begin
      w_req_pc_nx    = r_fpc;
      w_req_valid_nx = 1'b1;
      w_req_mis_nx   = 1'b0;
      w_fpc_nx       = r_fpc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fpc       <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_mis   <= 1'b0;
    end else begin
      r_fpc       <= w_fpc_nx;
      r_req_pc    <= w_req_pc_nx;
      r_req_valid <= w_req_valid_nx;
      r_req_mis   <= w_req_mis_nx;
    end
  end

  assign bus.rom_addr    = w_rom_addr;
  assign bus.if_pc       = r_req_pc;
  assign bus.if_valid    = r_req_valid;
  assign bus.if_misalign = r_req_mis & r_req_valid;
  assign bus.if_insn     = r_req_valid ? bus.rom_data : NOP_INSN;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table + scoreboard queue, plus
// hand-written reset/stall-while-invalid sequences.
import if_fetch_pkg::*;

module tb_if_fetch;

  logic clk;
  logic reset;

  if_fetch_if #(.AW(DEF_ROM_ADDR_W)) bus ();

  if_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  word_t mem [ROM_DEPTH];

  always_ff @(posedge clk)
    bus.rom_data <= mem[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    word_t       ba;
    logic [10:0] rom;
    word_t       pc;
    word_t       insn;
    logic        v;
    logic        mis;
  } vec_t;

  vec_t   tbl [19];
  if_id_t sbq [$];
  int     total;
  int     bad;

  task automatic chk(input string nm, input word_t got, input word_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_out(input string nm);
    if_id_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty-queue want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, ".pc"},   bus.if_pc, e.pc);
      chk({nm, ".insn"}, bus.if_insn, e.insn);
      chk({nm, ".v"},    {31'd0, bus.if_valid}, {31'd0, e.valid});
      chk({nm, ".mis"},  {31'd0, bus.if_misalign}, {31'd0, e.mis});
    end
  endtask

  task automatic step(input logic s, input logic b, input word_t a,
                      input word_t pc, input word_t insn,
                      input logic v, input logic m, input string nm);
    bus.stall    = s;
    bus.br_taken = b;
    bus.br_addr  = a;
    sbq.push_back('{pc: pc, insn: insn, valid: v, mis: m});
    @(posedge clk);
    #1;
    chk_out(nm);
  endtask

  localparam word_t B = 32'h1000_0000;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < ROM_DEPTH; i++)
      mem[i] = B + word_t'(i);

    tbl[0]  = '{0, 0, 32'h0,        11'h000, 32'h0,        B + 0,     1, 0};
    tbl[1]  = '{0, 0, 32'h0,        11'h001, 32'h4,        B + 1,     1, 0};
    tbl[2]  = '{0, 0, 32'h0,        11'h002, 32'h8,        B + 2,     1, 0};
    tbl[3]  = '{1, 0, 32'h0,        11'h002, 32'h8,        B + 2,     1, 0};
    tbl[4]  = '{1, 0, 32'h0,        11'h002, 32'h8,        B + 2,     1, 0};
    tbl[5]  = '{1, 0, 32'h0,        11'h002, 32'h8,        B + 2,     1, 0};
    tbl[6]  = '{0, 0, 32'h0,        11'h003, 32'hC,        B + 3,     1, 0};
    tbl[7]  = '{0, 1, 32'h40,       11'h010, 32'h40,       B + 'h10,  1, 0};
    tbl[8]  = '{0, 0, 32'h0,        11'h011, 32'h44,       B + 'h11,  1, 0};
    tbl[9]  = '{1, 1, 32'h20,       11'h008, 32'h20,       B + 8,     1, 0};
    tbl[10] = '{1, 0, 32'h0,        11'h008, 32'h20,       B + 8,     1, 0};
    tbl[11] = '{0, 0, 32'h0,        11'h009, 32'h24,       B + 9,     1, 0};
    tbl[12] = '{0, 1, 32'h22,       11'h008, 32'h20,       B + 8,     1, 1};
    tbl[13] = '{0, 0, 32'h0,        11'h009, 32'h24,       B + 9,     1, 0};
    tbl[14] = '{0, 1, 32'h2000,     11'h000, 32'h2000,     B + 0,     1, 0};
    tbl[15] = '{0, 0, 32'h0,        11'h001, 32'h2004,     B + 1,     1, 0};
    tbl[16] = '{0, 1, 32'hFFFF_FFFC, 11'h7FF, 32'hFFFF_FFFC, B + 'h7FF, 1, 0};
    tbl[17] = '{0, 0, 32'h0,        11'h000, 32'h0,        B + 0,     1, 0};
    tbl[18] = '{0, 1, 32'h30,       11'h00C, 32'h30,       B + 'hC,   1, 0};

    reset        = 1'b0;
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst.insn",  bus.if_insn, ISA_NOP);
    chk("rst.pc",    bus.if_pc, 32'h0);
    chk("rst.mis",   {31'd0, bus.if_misalign}, 32'd0);
    chk("rst.rom",   {21'd0, bus.rom_addr}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      bus.stall    = tbl[i].stall;
      bus.br_taken = tbl[i].br;
      bus.br_addr  = tbl[i].ba;
      #1;
      chk($sformatf("v%0d.rom", i), {21'd0, bus.rom_addr}, {21'd0, tbl[i].rom});
      sbq.push_back('{pc: tbl[i].pc, insn: tbl[i].insn,
                      valid: tbl[i].v, mis: tbl[i].mis});
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i));
    end

    // Async reset mid-stream while presenting pc 0x30.
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst.valid", {31'd0, bus.if_valid}, 32'd0);
    chk("arst.insn",  bus.if_insn, ISA_NOP);
    chk("arst.pc",    bus.if_pc, 32'h0);
    chk("arst.rom",   {21'd0, bus.rom_addr}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst.hold", {31'd0, bus.if_valid}, 32'd0);
    reset = 1'b1;

    step(1, 0, 32'h0, 32'h0, ISA_NOP, 0, 0, "stall_inv");
    step(0, 0, 32'h0, 32'h0, B + 0,   1, 0, "restart0");
    step(0, 0, 32'h0, 32'h4, B + 1,   1, 0, "restart1");
    step(0, 1, 32'h13, 32'h10, B + 4, 1, 1, "mis3");
    step(1, 0, 32'h0, 32'h10, B + 4,  1, 1, "mis_hold");
    step(0, 0, 32'h0, 32'h14, B + 5,  1, 0, "mis_clr");

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sbq_drain: got %0d want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
